tdm_frame_scheduler: RTL and testbench
======================================

TDM_FRAME_SCHEDULER -- requirements
Module: tdm_frame_scheduler

Interface
REQ-001 Parameter IDLE_BYTE, default 8'h00: byte driven into any slot with no fresh data.
REQ-002 Parameter SYNC_TIMEOUT, default 64: max clk cycles between sync_pulse before lock is lost.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_en  input  3  per-channel enable; bit0=ch1, bit1=ch2, bit2=ch3.
REQ-006 chN_data  input  8  requester N byte (N=1..3).
REQ-007 chN_valid  input  1  requester N byte offered.
REQ-008 chN_ready  output  1  scheduler accepts chN_data this cycle.
REQ-009 sync_pulse  input  1  one-cycle frame-boundary strobe from the encoder.
REQ-010 enc_ch1, enc_ch2, enc_ch3  output  8 each  bytes presented to the encoder channel inputs.
REQ-011 slot_fresh  output  3  bit N-1 high when enc_chN holds newly delivered data for the current frame.
REQ-012 locked  output  1  high in RUN state.
REQ-013 frame_count  output  8  frames scheduled since lock.
REQ-014 underrun_count  output  8  frames in which an enabled channel had no data.

Function
REQ-015 FSM states: WAIT_SYNC, RUN; reset state WAIT_SYNC.
REQ-016 WAIT_SYNC: all chN_ready=0, enc_chN=IDLE_BYTE, slot_fresh=0, locked=0; sync_pulse -> RUN, no slot transfer on that edge, frame_count=0.
REQ-017 Each channel has a 1-deep staging register with full flag; chN_ready = locked & ch_en[N-1] & !full, from registered state only.
REQ-018 Accept on chN_valid & chN_ready: staging <= chN_data, full <= 1, next edge.
REQ-019 RUN, sync_pulse: per enabled channel, full -> enc_chN <= staging, slot_fresh bit <= 1, full <= 0; not full -> enc_chN <= IDLE_BYTE, bit <= 0, underrun_count +1.
REQ-020 Accept and sync on the same edge (full was 0): transfer uses pre-edge state (IDLE_BYTE sent, underrun counted); accepted byte stays staged for the next frame.
REQ-021 Disabled channel: ready=0, full cleared next edge, IDLE_BYTE with slot_fresh bit 0 at each sync, no underrun counted.
REQ-022 enc_chN and slot_fresh change only on sync edges in RUN, else hold, so the encoder sees stable bytes for a full frame.
REQ-023 frame_count +1 per sync in RUN, wraps 255->0; underrun_count saturates at 255, counts once per sync if any enabled channel underruns.
REQ-024 Watchdog counter cleared on each sync; in RUN, count reaching SYNC_TIMEOUT-1 with no sync that cycle -> WAIT_SYNC; sync on that cycle wins and lock holds.
REQ-025 Entering WAIT_SYNC by timeout: all full flags cleared (staged bytes dropped), outputs per REQ-016; underrun_count retained.
REQ-026 Watchdog width is the minimum to hold SYNC_TIMEOUT-1; no arithmetic overflow permitted.

Reset
REQ-027 rst asserted: state WAIT_SYNC, full flags 0, staging 0, enc_chN=IDLE_BYTE, slot_fresh=0, locked=0, frame_count=0, underrun_count=0, watchdog 0, chN_ready=0, immediately and asynchronously.
REQ-028 Reset mid-frame discards staged data; release requires a fresh sync_pulse before any accept.

Structure
REQ-029 Shared package tdm_pkg holds NUM_CH=3, CH_W=8, state enumeration, default IDLE_BYTE.
REQ-030 Sub-module tdm_chan_stage (staging register, full flag, ready, transfer/flush controls) instantiated once per channel; FSM, watchdog and counters live in the top.

Verification
REQ-031 Lock: rst release, sync at cycle 10 -> locked=1 on next cycle, enc_chN=8'h00, frame_count=0, ready=1 for enabled channels.
REQ-032 Delivery: stage ch1=8'hAA, ch2=8'hCC, ch3=8'hF0, then sync -> enc=AA/CC/F0, slot_fresh=3'b111, frame_count=1, ready=1 again.
REQ-033 Underrun: only ch2=8'hCC staged, sync -> enc_ch1=enc_ch3=8'h00, slot_fresh=3'b010, underrun_count=1; second empty sync -> all 8'h00, underrun_count=2.
REQ-034 Same-edge accept: ch1_valid with 8'h55 coincident with sync, ch1 empty -> enc_ch1=8'h00 this frame, 8'h55 next sync.
REQ-035 Timeout: SYNC_TIMEOUT=64, no sync for 64 cycles after last sync -> locked=0, readies 0, enc all 8'h00, staged byte lost; sync exactly at cycle 63 keeps lock.
REQ-036 Disable/reset: clear ch_en[2] with 8'hF0 staged -> enc_ch3=8'h00, bit2=0, no underrun; rst mid-frame -> all outputs reset values immediately.

Source files
------------

// File: rtl/tdm_frame_scheduler_pkg.sv
// tdm_pkg: shared widths, channel count and FSM states for the TDM frame scheduler.
package tdm_pkg;
  localparam int NUM_CH = 3;
  localparam int CH_W = 8;
  localparam logic [CH_W-1:0] DEF_IDLE_BYTE = 8'h00;
  typedef enum logic {WAIT_SYNC, RUN} state_e;
endpackage

// File: rtl/tdm_chan_stage.sv
// tdm_chan_stage: one-deep staging register with full flag for a single TDM channel.
module tdm_chan_stage
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            xfer_i,
  input  logic            valid_i,
  input  logic [CH_W-1:0] data_i,
  output logic            ready_o,
  output logic            full_o,
  output logic [CH_W-1:0] stage_o
);
  logic            full_q, full_d, accept;
  logic [CH_W-1:0] stage_q, stage_d;
  assign ready_o = en_i & ~full_q;
  assign accept  = valid_i & ready_o;
  assign full_o  = full_q;
  assign stage_o = stage_q;
  // An accept coinciding with a transfer only happens when empty, so the new byte stays staged.
  always_comb begin
    full_d  = flush_i ? 1'b0 : accept ? 1'b1 : xfer_i ? 1'b0 : full_q;
    stage_d = accept ? data_i : stage_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      full_q  <= full_d;
      stage_q <= stage_d;
    end
  end
endmodule

// File: rtl/tdm_frame_scheduler.sv
// tdm_frame_scheduler: locks to encoder frame syncs and schedules three staged
// channel bytes into the encoder slots once per frame, with lock watchdog.
module tdm_frame_scheduler
  import tdm_pkg::*;
#(
  parameter logic [CH_W-1:0] IDLE_BYTE    = DEF_IDLE_BYTE,
  parameter int              SYNC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [CH_W-1:0]   ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  input  logic [CH_W-1:0]   ch2_data,
  input  logic              ch2_valid,
  output logic              ch2_ready,
  input  logic [CH_W-1:0]   ch3_data,
  input  logic              ch3_valid,
  output logic              ch3_ready,
  input  logic              sync_pulse,
  output logic [CH_W-1:0]   enc_ch1,
  output logic [CH_W-1:0]   enc_ch2,
  output logic [CH_W-1:0]   enc_ch3,
  output logic [NUM_CH-1:0] slot_fresh,
  output logic              locked,
  output logic [7:0]        frame_count,
  output logic [7:0]        underrun_count
);
  localparam int WD_W = SYNC_TIMEOUT > 1 ? $clog2(SYNC_TIMEOUT) : 1;
  state_e                        state_q, state_d;
  logic [WD_W-1:0]               wd_q, wd_d;
  logic [7:0]                    frame_q, frame_d, und_q, und_d;
  logic [NUM_CH-1:0][CH_W-1:0]   enc_q, enc_d, data, stage;
  logic [NUM_CH-1:0]             fresh_q, fresh_d, full, ready, valid, flush;
  logic                          run, sync_run, timeout;
  assign run      = state_q == RUN;
  assign sync_run = run & sync_pulse;
  assign timeout  = run & ~sync_pulse & (wd_q == WD_W'(SYNC_TIMEOUT - 1));
  assign valid    = {ch3_valid, ch2_valid, ch1_valid};
  assign data     = {ch3_data, ch2_data, ch1_data};
  // Losing lock drops staged bytes; disabled channels never hold data.
  assign flush    = ~ch_en | {NUM_CH{timeout}};
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      tdm_chan_stage u_stage (
        .clk    (clk),
        .rst    (rst),
        .en_i   (run & ch_en[i]),
        .flush_i(flush[i]),
        .xfer_i (sync_run),
        .valid_i(valid[i]),
        .data_i (data[i]),
        .ready_o(ready[i]),
        .full_o (full[i]),
        .stage_o(stage[i])
      );
    end
  endgenerate
  always_comb begin
    state_d = run ? (timeout ? WAIT_SYNC : RUN) : (sync_pulse ? RUN : WAIT_SYNC);
    wd_d    = (sync_pulse | ~run) ? '0 : wd_q + WD_W'(1);
    frame_d = sync_pulse ? (run ? frame_q + 8'd1 : 8'd0) : frame_q;
    und_d   = (sync_run & |(ch_en & ~full) & (und_q != 8'hFF)) ? und_q + 8'd1 : und_q;
    fresh_d = timeout ? '0 : sync_run ? (ch_en & full) : fresh_q;
    for (int n = 0; n < NUM_CH; n++)
      enc_d[n] = timeout ? IDLE_BYTE :
                 sync_run ? ((ch_en[n] & full[n]) ? stage[n] : IDLE_BYTE) : enc_q[n];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      wd_q    <= '0;
      frame_q <= '0;
      und_q   <= '0;
      fresh_q <= '0;
      enc_q   <= {NUM_CH{IDLE_BYTE}};
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      frame_q <= frame_d;
      und_q   <= und_d;
      fresh_q <= fresh_d;
      enc_q   <= enc_d;
    end
  end
  assign enc_ch1        = enc_q[0];
  assign enc_ch2        = enc_q[1];
  assign enc_ch3        = enc_q[2];
  assign slot_fresh     = fresh_q;
  assign locked         = run;
  assign frame_count    = frame_q;
  assign underrun_count = und_q;
  assign ch1_ready      = ready[0];
  assign ch2_ready      = ready[1];
  assign ch3_ready      = ready[2];
endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// tb_tdm_frame_scheduler: directed vector table plus timeout and reset sequences.
module tb_tdm_frame_scheduler;
  logic       clk = 1'b0, rst = 1'b1, sync_pulse = 1'b0;
  logic [2:0] ch_en = 3'b111;
  logic [7:0] ch1_data = 8'h00, ch2_data = 8'h00, ch3_data = 8'h00;
  logic       ch1_valid = 1'b0, ch2_valid = 1'b0, ch3_valid = 1'b0;
  logic       ch1_ready, ch2_ready, ch3_ready, locked;
  logic [7:0] enc_ch1, enc_ch2, enc_ch3, frame_count, underrun_count;
  logic [2:0] slot_fresh;
  int tests = 0, fails = 0;

  typedef struct {
    logic s; logic [2:0] en; logic [2:0] v; logic [7:0] d1, d2, d3;
    logic [7:0] e1, e2, e3; logic [2:0] fr; logic lk; logic [7:0] fc, uc; logic [2:0] rdy;
  } vec_t;
  vec_t vec [16];

  tdm_frame_scheduler #(.IDLE_BYTE(8'h00), .SYNC_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .ch2_data(ch2_data), .ch2_valid(ch2_valid), .ch2_ready(ch2_ready),
    .ch3_data(ch3_data), .ch3_valid(ch3_valid), .ch3_ready(ch3_ready),
    .sync_pulse(sync_pulse), .enc_ch1(enc_ch1), .enc_ch2(enc_ch2), .enc_ch3(enc_ch3),
    .slot_fresh(slot_fresh), .locked(locked), .frame_count(frame_count),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e1, e2, e3, input logic [2:0] fr,
                           input logic lk, input logic [7:0] fc, uc, input logic [2:0] rdy);
    chk({tag, ".enc_ch1"}, enc_ch1, e1);
    chk({tag, ".enc_ch2"}, enc_ch2, e2);
    chk({tag, ".enc_ch3"}, enc_ch3, e3);
    chk({tag, ".slot_fresh"}, slot_fresh, fr);
    chk({tag, ".locked"}, locked, lk);
    chk({tag, ".frame_count"}, frame_count, fc);
    chk({tag, ".underrun_count"}, underrun_count, uc);
    chk({tag, ".ready"}, {ch3_ready, ch2_ready, ch1_ready}, rdy);
  endtask

  task automatic drive(input logic s, input logic [2:0] en, input logic [2:0] v,
                       input logic [7:0] d1, d2, d3);
    @(negedge clk);
    sync_pulse = s; ch_en = en;
    {ch3_valid, ch2_valid, ch1_valid} = v;
    ch1_data = d1; ch2_data = d2; ch3_data = d3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0, 8'd0, 3'd0};
    vec[1]  = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd0, 8'd0, 3'd7};
    vec[2]  = '{1'b0, 3'd7, 3'd7, 8'hAA, 8'hCC, 8'hF0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd0, 8'd0, 3'd0};
    vec[3]  = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hCC, 8'hF0, 3'd7, 1'b1, 8'd1, 8'd0, 3'd7};
    vec[4]  = '{1'b0, 3'd7, 3'd2, 8'h00, 8'hCC, 8'h00, 8'hAA, 8'hCC, 8'hF0, 3'd7, 1'b1, 8'd1, 8'd0, 3'd5};
    vec[5]  = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hCC, 8'h00, 3'd2, 1'b1, 8'd2, 8'd1, 3'd7};
    vec[6]  = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd3, 8'd2, 3'd7};
    vec[7]  = '{1'b1, 3'd7, 3'd1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd4, 8'd3, 3'd6};
    vec[8]  = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 3'd1, 1'b1, 8'd5, 8'd4, 3'd7};
    vec[9]  = '{1'b0, 3'd7, 3'd4, 8'h00, 8'h00, 8'hF0, 8'h55, 8'h00, 8'h00, 3'd1, 1'b1, 8'd5, 8'd4, 3'd3};
    vec[10] = '{1'b1, 3'd7, 3'd3, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'hF0, 3'd4, 1'b1, 8'd6, 8'd5, 3'd4};
    vec[11] = '{1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 3'd3, 1'b1, 8'd7, 8'd6, 3'd7};
    vec[12] = '{1'b0, 3'd7, 3'd7, 8'h01, 8'h02, 8'hF0, 8'h11, 8'h22, 8'h00, 3'd3, 1'b1, 8'd7, 8'd6, 3'd0};
    vec[13] = '{1'b0, 3'd3, 3'd0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 3'd3, 1'b1, 8'd7, 8'd6, 3'd0};
    vec[14] = '{1'b1, 3'd3, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 3'd3, 1'b1, 8'd8, 8'd6, 3'd3};
    vec[15] = '{1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 3'd3, 1'b1, 8'd8, 8'd6, 3'd7};

    #1;
    check_out("reset", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0, 8'd0, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 8; k++) drive(1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 16; k++) begin
      drive(vec[k].s, vec[k].en, vec[k].v, vec[k].d1, vec[k].d2, vec[k].d3);
      check_out($sformatf("vec%0d", k), vec[k].e1, vec[k].e2, vec[k].e3, vec[k].fr,
                vec[k].lk, vec[k].fc, vec[k].uc, vec[k].rdy);
    end

    // Watchdog: a sync on the 64th edge after the last one keeps lock.
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("wd_sync", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd9, 8'd7, 3'd7);
    for (int k = 0; k < 63; k++) drive(1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("wd_63", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd9, 8'd7, 3'd7);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("wd_keep", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd10, 8'd8, 3'd7);
    drive(1'b0, 3'd7, 3'd1, 8'h77, 8'h00, 8'h00);
    for (int k = 0; k < 62; k++) drive(1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("wd_pre", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd10, 8'd8, 3'd6);
    drive(1'b0, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("wd_lost", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'd10, 8'd8, 3'd0);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("relock", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd0, 8'd8, 3'd7);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("dropped", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd1, 8'd9, 3'd7);

    // Asynchronous reset mid-frame with live encoder data and a staged byte.
    drive(1'b0, 3'd7, 3'd1, 8'h99, 8'h00, 8'h00);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("pre_rst", 8'h99, 8'h00, 8'h00, 3'd1, 1'b1, 8'd2, 8'd10, 3'd7);
    drive(1'b0, 3'd7, 3'd2, 8'h00, 8'h33, 8'h00);
    check_out("stage_rst", 8'h99, 8'h00, 8'h00, 3'd1, 1'b1, 8'd2, 8'd10, 3'd5);
    #1 rst = 1'b1;
    #1 check_out("async_rst", 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0, 8'd0, 3'd0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd7, 3'd7, 8'h12, 8'h34, 8'h56);
      check_out($sformatf("post_rst%0d", k), 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0, 8'd0, 3'd0);
    end
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("rst_lock", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd0, 8'd0, 3'd7);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00);
    check_out("rst_empty", 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 8'd1, 8'd1, 3'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
